// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 keyboard frame receiver with make/break/extended decode and held-key bitmap
// Optional macro PS2_PARITY_CHECK_EN: when defined, odd-parity errors discard the byte and raise frame_err.
module ps2_key_tracker #(
    parameter int NUM_KEYS       = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                ps2_clk,
    input  logic                ps2_dat,
    output logic [NUM_KEYS-1:0] keys_held,
    output logic                key_valid,
    output logic [3:0]          key_index,
    output logic                key_release,
    output logic [7:0]          last_code,
    output logic                frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic [TW-1:0]          r_to_cnt;
    logic                   r_break_pend;
    logic                   r_ext_pend;
    logic [NUM_KEYS-1:0]    r_keys_held;
    logic                   r_key_valid;
    logic [3:0]             r_key_index;
    logic                   r_key_release;
    logic [7:0]             r_last_code;
    logic                   r_frame_err;

    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_fall;
    logic                   w_timeout;
    logic                   w_par_ok;
    logic                   w_stop_edge;
    logic                   w_stop_ok;
    logic                   w_stop_err;
    logic                   w_code_hit;
    logic [3:0]             w_idx;
    logic [NUM_KEYS-1:0]    w_mask;
    logic                   w_hit;
    logic                   w_is_held;

    // Idle PS/2 bus is high, so the synchronisers reset to 1 to avoid a false edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    assign w_timeout = (r_state != S_IDLE) && !w_fall &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_parity <= 1'b0;
        end else if (w_fall && r_state == S_PARITY) begin
            r_parity <= w_dat_s;
        end
    end

    assign w_par_ok = ^{r_shift, r_parity};
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_stop_edge = w_fall && (r_state == S_STOP);
    assign w_stop_ok   = w_stop_edge && w_dat_s && w_par_ok;
    assign w_stop_err  = w_stop_edge && !(w_dat_s && w_par_ok);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fall && !w_dat_s)          w_state_nxt = S_DATA;
            S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (w_fall)                      w_state_nxt = S_STOP;
            S_STOP:   if (w_fall)                      w_state_nxt = S_IDLE;
            default:                                   w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (w_fall) begin
            if (r_state == S_IDLE) begin
                r_bit_cnt <= 3'd0;
            end else if (r_state == S_DATA) begin
                r_shift   <= {w_dat_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if (r_state == S_IDLE || w_fall || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        w_code_hit = 1'b1;
        w_idx      = 4'd0;
        case (r_shift)
            8'h1C: w_idx = 4'd0;
            8'h1B: w_idx = 4'd1;
            8'h23: w_idx = 4'd2;
            8'h2B: w_idx = 4'd3;
            8'h34: w_idx = 4'd4;
            8'h33: w_idx = 4'd5;
            8'h3B: w_idx = 4'd6;
            8'h42: w_idx = 4'd7;
            8'h1D: w_idx = 4'd8;
            8'h24: w_idx = 4'd9;
            8'h2C: w_idx = 4'd10;
            8'h35: w_idx = 4'd11;
            8'h3C: w_idx = 4'd12;
            default: w_code_hit = 1'b0;
        endcase
    end

    // Indices beyond NUM_KEYS shift out of the mask, which makes them untracked
    assign w_mask    = NUM_KEYS'(1) << w_idx;
    assign w_hit     = w_code_hit && (|w_mask);
    assign w_is_held = |(r_keys_held & w_mask);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_break_pend  <= 1'b0;
            r_ext_pend    <= 1'b0;
            r_keys_held   <= '0;
            r_key_valid   <= 1'b0;
            r_key_index   <= 4'd0;
            r_key_release <= 1'b0;
            r_last_code   <= 8'h00;
            r_frame_err   <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_frame_err <= w_stop_err | w_timeout;
            if (w_stop_ok) begin
                if (r_shift == 8'hF0) begin
                    r_break_pend <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else begin
                    r_last_code  <= r_shift;
                    r_break_pend <= 1'b0;
                    r_ext_pend   <= 1'b0;
                    if (!r_ext_pend && w_hit) begin
                        if (r_break_pend && w_is_held) begin
                            r_keys_held   <= r_keys_held & ~w_mask;
                            r_key_valid   <= 1'b1;
                            r_key_index   <= w_idx;
                            r_key_release <= 1'b1;
                        end else if (!r_break_pend && !w_is_held) begin
                            r_keys_held   <= r_keys_held | w_mask;
                            r_key_valid   <= 1'b1;
                            r_key_index   <= w_idx;
                            r_key_release <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign keys_held   = r_keys_held;
    assign key_valid   = r_key_valid;
    assign key_index   = r_key_index;
    assign key_release = r_key_release;
    assign last_code   = r_last_code;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

    localparam int NUM_KEYS = 8;
    localparam int TIMEOUT  = 200;

    logic                clock;
    logic                resetn;
    logic                ps2_clk;
    logic                ps2_dat;
    logic [NUM_KEYS-1:0] keys_held;
    logic                key_valid;
    logic [3:0]          key_index;
    logic                key_release;
    logic [7:0]          last_code;
    logic                frame_err;

    int n_checks;
    int n_fail;
    int n_valid;
    int n_ferr;
    int exp_valid;
    int exp_ferr;
    logic [NUM_KEYS-1:0] exp_held;

    ps2_key_tracker #(
        .NUM_KEYS      (NUM_KEYS),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (2)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .keys_held  (keys_held),
        .key_valid  (key_valid),
        .key_index  (key_index),
        .key_release(key_release),
        .last_code  (last_code),
        .frame_err  (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (key_valid) n_valid++;
        if (frame_err) n_ferr++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (5) @(posedge clock);
        ps2_clk = 1'b0;
        repeat (5) @(posedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par_flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
        ps2_bit(1'b1);
        repeat (10) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_valid = 0; n_ferr = 0;
        exp_valid = 0; exp_ferr = 0; exp_held = '0;
        resetn = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (4) @(negedge clock);
        check_eq("rst_held", keys_held, 0);
        check_eq("rst_last", last_code, 0);
        check_eq("rst_valid", key_valid, 0);
        check_eq("rst_ferr", frame_err, 0);
        resetn = 1'b1;
        repeat (4) @(negedge clock);

        send_byte(8'h1C, 1'b0);
        check_eq("make1c_held", keys_held, 8'h01);
        check_eq("make1c_cnt", n_valid, 1);
        check_eq("make1c_idx", key_index, 0);
        check_eq("make1c_rel", key_release, 0);
        check_eq("make1c_last", last_code, 8'h1C);

        send_byte(8'h23, 1'b0);
        check_eq("make23_held", keys_held, 8'h05);
        check_eq("make23_idx", key_index, 2);
        send_byte(8'hF0, 1'b0);
        check_eq("f0_noevent", n_valid, 2);
        send_byte(8'h1C, 1'b0);
        check_eq("brk1c_held", keys_held, 8'h04);
        check_eq("brk1c_cnt", n_valid, 3);
        check_eq("brk1c_idx", key_index, 0);
        check_eq("brk1c_rel", key_release, 1);

        for (int i = 0; i < 3; i++) begin
            send_byte(8'h1B, 1'b0);
            check_eq("rep1b_held1", keys_held[1], 1);
        end
        check_eq("rep1b_cnt", n_valid, 4);
        check_eq("rep1b_held", keys_held, 8'h06);
        check_eq("rep1b_rel", key_release, 0);
        exp_held = 8'h06; exp_valid = 4;

        send_byte(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        exp_ferr = exp_ferr + 1;
`else
        exp_held = exp_held | 8'h01;
        exp_valid = exp_valid + 1;
`endif
        check_eq("par_held", keys_held, exp_held);
        check_eq("par_ferr", n_ferr, exp_ferr);
        check_eq("par_cnt", n_valid, exp_valid);

        send_byte(8'hF0, 1'b0);
        send_byte(8'h42, 1'b0);
        check_eq("brk_unheld_cnt", n_valid, exp_valid);
        check_eq("brk_unheld_last", last_code, 8'h42);
        send_byte(8'h3C, 1'b0);
        check_eq("oor_cnt", n_valid, exp_valid);
        check_eq("oor_held", keys_held, exp_held);
        check_eq("oor_last", last_code, 8'h3C);

        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (TIMEOUT + 20) @(posedge clock);
        @(negedge clock);
        exp_ferr = exp_ferr + 1;
        check_eq("timeout_ferr", n_ferr, exp_ferr);
        check_eq("timeout_cnt", n_valid, exp_valid);
        send_byte(8'h2B, 1'b0);
        exp_held = exp_held | 8'h08; exp_valid = exp_valid + 1;
        check_eq("after_to_held", keys_held, exp_held);
        check_eq("after_to_idx", key_index, 3);
        check_eq("after_to_ferr", n_ferr, exp_ferr);

        send_byte(8'h42, 1'b0);
        exp_held = exp_held | 8'h80; exp_valid = exp_valid + 1;
        check_eq("make42_held", keys_held, exp_held);
        check_eq("make42_idx", key_index, 7);

        send_byte(8'hE0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check_eq("ext_cnt", n_valid, exp_valid);
        check_eq("ext_held", keys_held, exp_held);
        check_eq("ext_last", last_code, 8'h1C);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h2B, 1'b0);
        check_eq("extbrk_cnt", n_valid, exp_valid);
        check_eq("extbrk_held", keys_held, exp_held);
        check_eq("extbrk_last", last_code, 8'h2B);

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check_eq("arst_held", keys_held, 0);
        check_eq("arst_idx", key_index, 0);
        check_eq("arst_last", last_code, 0);
        check_eq("arst_valid", key_valid, 0);
        check_eq("arst_ferr", frame_err, 0);
        ps2_dat = 1'b1;
        repeat (3) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
